// File: rtl/sin_table_loader.sv
// sin_table_loader: fills the SPRAM sine table from a byte stream, then gives the read port to the DDS.
// Optional trailer checksum verification when CHECKSUM_EN is defined.
module sin_table_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter bit LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [ADDR_W-1:0] dds_addr,
    output logic [DATA_W-1:0] dds_data
);
    typedef enum logic [2:0] {IDLE, B0, B1, WR, CS0, CS1, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [7:0] first;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] pair;
    logic xfer, last, idle_like;
    assign xfer = in_valid && in_ready;
    assign last = &cnt;
    assign idle_like = state inside {IDLE, DONE, ERR};
    assign pair = LSB_FIRST ? {in_data, first} : {first, in_data};
    assign ram_wdata = word;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) sum <= '0;
        else if (idle_like && start) sum <= '0;
        else if (state == WR) sum <= sum + word;
`endif
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = B0;
            B0: if (xfer) state_nx = B1;
            B1: if (xfer) state_nx = WR;
`ifdef CHECKSUM_EN
            WR: state_nx = last ? CS0 : B0;
            CS0: if (xfer) state_nx = CS1;
            CS1: if (xfer) state_nx = (pair == sum) ? DONE : ERR;
`else
            WR: state_nx = last ? DONE : B0;
`endif
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready = state inside {B0, B1, CS0, CS1};
        busy = !idle_like;
        done = state == DONE;
        ram_we = state == WR;
        ram_addr = (state == DONE) ? dds_addr : cnt;
        dds_data = (state == DONE) ? ram_rdata : '0;
`ifdef CHECKSUM_EN
        error = state == ERR;
`else
        error = 1'b0;
`endif
    end
    // counter wraps to 0 on the final write, so a reload starts from a clean address
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            cnt <= '0;
            first <= '0;
            word <= '0;
        end else begin
            if (idle_like && start) cnt <= '0;
            else if (state == WR) cnt <= cnt + 1'b1;
            if (xfer && (state == B0 || state == CS0)) first <= in_data;
            if (xfer && state == B1) word <= pair;
        end
endmodule
